reg_mem_bist: RTL

- Sequencer directly upstream of reg_mem; owns its addr, data_in and wen inputs and consumes its data_out.
- On start, writes a deterministic pattern to every address, reads every address back and compares against the expected value.
- Reports pass/fail, error count and first failing address.
- Used as the power-on/self-test driver for the register memory and as the stimulus source for reg_mem in system simulation.

---
 rtl/reg_mem_pkg.sv | 22 ++
 rtl/bist_checker.sv | 81 ++++++++
 rtl/reg_mem_bist.sv | 108 ++++++++++
 3 files changed

// File: rtl/reg_mem_pkg.sv
// Shared definitions for the register memory and its built-in self-test sequencer.
package reg_mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 5;
    localparam int PAT_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } bist_state_e;

    // Callers cast the result down to their word width, which gives the modular add.
    function automatic logic [PAT_W-1:0] expected(input logic [PAT_W-1:0] base,
                                                  input logic [PAT_W-1:0] addr);
        return base + addr;
    endfunction

endpackage

// File: rtl/bist_checker.sv
// Read-back comparator: optional one-stage alignment delay, saturating error
// counter and first-failing-address capture.
module bist_checker
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  cmp_en_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [ADDR_BITS:0]    err_count_o,
    output logic [ADDR_BITS-1:0]  first_err_addr_o
);

    logic                  chk_vld;
    logic [ADDR_BITS-1:0]  chk_addr;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic                  mismatch;
    logic [ADDR_BITS:0]    err_q, err_d;
    logic [ADDR_BITS-1:0]  first_q, first_d;

    if (READ_LATENCY == 1) begin : g_delay
        logic                  vld_q;
        logic [ADDR_BITS-1:0]  addr_q;
        logic [DATA_WIDTH-1:0] exp_q;

        always_ff @(posedge clk) begin
            if (!rst_n || clear_i) begin
                vld_q  <= 1'b0;
                addr_q <= '0;
                exp_q  <= '0;
            end else begin
                vld_q  <= cmp_en_i;
                addr_q <= addr_i;
                exp_q  <= exp_i;
            end
        end

        assign chk_vld  = vld_q;
        assign chk_addr = addr_q;
        assign chk_exp  = exp_q;
    end else begin : g_direct
        assign chk_vld  = cmp_en_i;
        assign chk_addr = addr_i;
        assign chk_exp  = exp_i;
    end

    assign mismatch = chk_vld && (data_i != chk_exp);

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (clear_i) begin
            err_d   = '0;
            first_d = '0;
        end else if (mismatch) begin
            if (err_q != '1) err_d = err_q + (ADDR_BITS+1)'(1);
            if (err_q == '0) first_d = chk_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q   <= '0;
            first_q <= '0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: rtl/reg_mem_bist.sv
// Self-test sequencer for reg_mem: write base+addr everywhere, read back, compare.
// IDLE: wait for start | WRITE: one write per addr | READ: one read per addr | DRAIN: last compare (latency 1) | DONE: result pulse
module reg_mem_bist
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS:0]    err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    bist_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic                  pass_q, pass_d;
    logic                  clear;
    logic                  active;
    logic [DATA_WIDTH-1:0] exp_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        pass_d  = pass_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    clear   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + ADDR_BITS'(1);
                if (cnt_q == LAST_ADDR) state_d = READ;
            end
            READ: begin
                cnt_d = cnt_q + ADDR_BITS'(1);
                if (cnt_q == LAST_ADDR) state_d = (READ_LATENCY == 1) ? DRAIN : DONE;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                pass_d  = (err_count == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pass_q  <= pass_d;
        end
    end

    assign active      = (state_q == WRITE) || (state_q == READ);
    assign exp_word    = DATA_WIDTH'(expected(PAT_W'(base_q), PAT_W'(cnt_q)));
    assign mem_wen     = (state_q == WRITE);
    assign mem_addr    = active ? cnt_q : '0;
    assign mem_data_in = active ? exp_word : '0;
    assign busy        = active || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    // The final compare lands on the edge into DONE, so the live count is already complete.
    assign pass        = done ? (err_count == '0) : pass_q;

    bist_checker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_BITS   (ADDR_BITS),
        .READ_LATENCY(READ_LATENCY)
    ) u_checker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (clear),
        .cmp_en_i        (state_q == READ),
        .addr_i          (cnt_q),
        .exp_i           (exp_word),
        .data_i          (mem_data_out),
        .err_count_o     (err_count),
        .first_err_addr_o(first_err_addr)
    );

endmodule
